// File: rtl/mips_avalon_pkg.sv
// Shared types and helpers for the Avalon-MM memory responder.
//   state_e   : responder FSM states
//   addr_map_t: word index plus in-window flag for a byte address
//   map_addr(): maps a byte address onto the RAM window
package mips_avalon_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [0:0] {
    StIdle,
    StStall
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] idx;
    logic              in_range;
  } addr_map_t;

  // The lower-bound compare gates the subtraction result, so addresses below
  // the base cannot wrap around and alias into the window.
  function automatic addr_map_t map_addr(input logic [WORD_W-1:0] addr,
                                         input logic [WORD_W-1:0] base,
                                         input int unsigned       words);
    addr_map_t         m;
    logic [WORD_W-1:0] off;
    off        = addr - base;
    m.idx      = off >> 2;
    m.in_range = (addr >= base) && (m.idx < words) && (addr[1:0] == 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/mips_avalon_mem_array.sv
// Synchronous byte-lane RAM: four 8-bit lanes sharing one address.
//   clk   : clock
//   addr  : word index
//   we/be : write strobe and per-lane enables (be[0] -> wdata[7:0])
//   wdata : write data
//   re    : read strobe; rdata is registered and holds when re is low
//   rdata : registered read data
module mips_avalon_mem_array
  import mips_avalon_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && be[g]) begin
        mem[addr] <= wdata[8*g +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (re) begin
        rd_q <= mem[addr];
      end
    end

    assign rdata[8*g +: 8] = rd_q;
  end

endmodule

// File: rtl/mips_avalon_mem_responder.sv
// Avalon-MM memory slave with a fixed number of wait states per transfer.
//   clk, reset     : clock, synchronous active-high reset
//   address        : byte address of the transfer
//   read, write    : request strobes
//   byteenable     : write lane enables
//   writedata      : write data
//   waitrequest    : high while the request has not been accepted
//   readdata       : read data, valid the cycle after read acceptance
//   protocol_error : sticky, initiator broke the request-hold rules
//   range_error    : sticky, access outside the window or misaligned
module mips_avalon_mem_responder
  import mips_avalon_pkg::*;
#(
  parameter int unsigned       MEM_WORDS   = 1024,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [WORD_W-1:0] writedata,
  output logic              waitrequest,
  output logic [WORD_W-1:0] readdata,
  output logic              protocol_error,
  output logic              range_error
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_CYCLES);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;

  logic [WORD_W-1:0] lat_addr_q, lat_wdata_q;
  logic              lat_read_q, lat_write_q;
  logic [BE_W-1:0]   lat_be_q;
  logic              poison_q;

  logic              req, both, same;
  logic              accept, latch_en, perr_now;

  logic [WORD_W-1:0] xfer_addr;
  logic              xfer_read, xfer_write, xfer_bad;
  addr_map_t         map;
  logic              ok, ram_we, ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              rd_zero_q;
  logic              perr_q, rerr_q;
  logic              unused_idx;

  assign req  = read | write;
  assign both = read & write;
  assign same = (address == lat_addr_q) && (read == lat_read_q) && (write == lat_write_q) &&
                (byteenable == lat_be_q) && (writedata == lat_wdata_q);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (req && !ZERO_WAIT) begin
          state_d = StStall;
          count_d = 4'd1;
        end
      end
      StStall: begin
        if (!req || (count_q >= WAIT_CNT)) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    waitrequest = 1'b0;
    accept      = 1'b0;
    latch_en    = 1'b0;
    perr_now    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          perr_now = both;
          if (ZERO_WAIT) begin
            accept = 1'b1;
          end else begin
            waitrequest = 1'b1;
            latch_en    = 1'b1;
          end
        end
      end
      StStall: begin
        waitrequest = (count_q < WAIT_CNT);
        if (!req) begin
          perr_now = 1'b1;
        end else begin
          perr_now = !same;
          accept   = (count_q >= WAIT_CNT);
        end
      end
      default: ;
    endcase
  end

  // The transfer executed at acceptance: latched copy after a stall, live bus
  // when there are no wait states. A poisoned transfer completes as a no-op.
  always_comb begin
    if (state_q == StStall) begin
      xfer_addr  = lat_addr_q;
      xfer_read  = lat_read_q;
      xfer_write = lat_write_q;
      xfer_bad   = poison_q | !same;
    end else begin
      xfer_addr  = address;
      xfer_read  = read;
      xfer_write = write;
      xfer_bad   = both;
    end
  end

  assign map        = map_addr(xfer_addr, BASE_ADDR, MEM_WORDS);
  assign unused_idx = ^map.idx[WORD_W-1:AW];

  // Reset wins over a coincident acceptance so an abandoned write never lands.
  assign ok     = accept && !xfer_bad && !reset;
  assign ram_we = ok && xfer_write && map.in_range;
  assign ram_re = ok && xfer_read && map.in_range;

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_addr_q  <= address;
      lat_read_q  <= read;
      lat_write_q <= write;
      lat_be_q    <= byteenable;
      lat_wdata_q <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      poison_q  <= 1'b0;
      rd_zero_q <= 1'b1;
      perr_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      if (latch_en) begin
        poison_q <= both;
      end else if (perr_now) begin
        poison_q <= 1'b1;
      end
      if (perr_now) begin
        perr_q <= 1'b1;
      end
      if (ok && !map.in_range) begin
        rerr_q <= 1'b1;
      end
      // Out-of-window reads present zero without touching the RAM register.
      if (ok && xfer_read) begin
        rd_zero_q <= !map.in_range;
      end
    end
  end

  mips_avalon_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .addr  (map.idx[AW-1:0]),
    .we    (ram_we),
    .be    ((state_q == StStall) ? lat_be_q : byteenable),
    .wdata ((state_q == StStall) ? lat_wdata_q : writedata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  assign readdata       = rd_zero_q ? '0 : ram_rdata;
  assign protocol_error = perr_q;
  assign range_error    = rerr_q;

endmodule
